i2s_frame_ctrl: RTL and testbench

- I2S bus master controller. It derives the serial bit clock (SCLK) and word select (WS) from the system clock and sequences whole stereo frames.
- It issues per-edge strobes and frame-complete pulses so the I2S receive/transmit datapaths and the sample FIFO can run framed, MSB-first, 2-slot audio.
- Start and stop are clean and occur only at frame boundaries. The divider is reprogrammable per frame.

---
 rtl/i2s_frame_ctrl_if.sv | 30 +++
 rtl/i2s_frame_ctrl.sv | 125 ++++++++++++
 tb/tb_i2s_frame_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_frame_ctrl_if.sv
// Bus bundle for the I2S frame controller: run/divider controls in,
// generated bit clock, word select, strobes and frame status out.
interface i2s_frame_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8
);
    localparam int CNT_W = $clog2(2 * WIDTH);

    logic             en_i;
    logic [DIV_W-1:0] div_i;
    logic             sclk_o;
    logic             ws_o;
    logic             sclkRise_o;
    logic             sclkFall_o;
    logic [CNT_W-1:0] slotBit_o;
    logic             frameDone_o;
    logic             busy_o;

    // Controller side: generates the I2S clocks
    modport master (
        input  en_i, div_i,
        output sclk_o, ws_o, sclkRise_o, sclkFall_o, slotBit_o, frameDone_o, busy_o
    );

    // Client side: requests runs and consumes the clocks/strobes
    modport slave (
        output en_i, div_i,
        input  sclk_o, ws_o, sclkRise_o, sclkFall_o, slotBit_o, frameDone_o, busy_o
    );
endinterface

// File: rtl/i2s_frame_ctrl.sv
// I2S bus master frame controller. Divides clk_i into SCLK, counts bits of a
// 2-slot frame, drives WS with the standard one-bit delay, and starts/stops
// only on frame boundaries. The divider is relatched at every frame wrap.
module i2s_frame_ctrl #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    i2s_frame_ctrl_if.master   bus
);
    localparam int CNT_W = $clog2(2 * WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(2 * WIDTH - 1);
    localparam logic [CNT_W-1:0] WS_LO = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] WS_HI = CNT_W'(2 * WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] halfCnt_q, halfCnt_d;
    logic [DIV_W-1:0] divLat_q, divLat_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic             sclk_q, sclk_d;
    logic             ws_q, ws_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Next-state, divider, bit counter and registered-output precomputation
    always_comb begin
        state_d   = state_q;
        halfCnt_d = halfCnt_q;
        divLat_d  = divLat_q;
        bitCnt_d  = bitCnt_q;
        sclk_d    = sclk_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                halfCnt_d = '0;
                bitCnt_d  = '0;
                sclk_d    = 1'b0;
                if (bus.en_i) begin
                    divLat_d = bus.div_i;
                    state_d  = RUN;
                end
            end
            RUN, STOP: begin
                if (halfCnt_q == divLat_q) begin
                    halfCnt_d = '0;
                    sclk_d    = ~sclk_q;
                    rise_d    = ~sclk_q;
                    fall_d    = sclk_q;
                end else begin
                    halfCnt_d = halfCnt_q + DIV_W'(1);
                end

                if (fall_d) begin
                    if (bitCnt_q == LAST) begin
                        bitCnt_d = '0;
                        done_d   = 1'b1;
                        divLat_d = bus.div_i;
                    end else begin
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end

                // en_i low on the wrap itself stops right here rather than
                // detouring through STOP for one more frame
                if (state_q == RUN) begin
                    if (!bus.en_i) state_d = done_d ? IDLE : STOP;
                end else begin
                    if (bus.en_i)      state_d = RUN;
                    else if (done_d)   state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ws_d   = (bitCnt_d >= WS_LO) && (bitCnt_d <= WS_HI);
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            halfCnt_q <= '0;
            divLat_q  <= '0;
            bitCnt_q  <= '0;
            sclk_q    <= 1'b0;
            ws_q      <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            halfCnt_q <= halfCnt_d;
            divLat_q  <= divLat_d;
            bitCnt_q  <= bitCnt_d;
            sclk_q    <= sclk_d;
            ws_q      <= ws_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.sclk_o      = sclk_q;
    assign bus.ws_o        = ws_q;
    assign bus.sclkRise_o  = rise_q;
    assign bus.sclkFall_o  = fall_q;
    assign bus.slotBit_o   = bitCnt_q;
    assign bus.frameDone_o = done_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl: a start-up vector table plus
// hand-written sequences for stop, divider change, re-enable and reset.
module tb_i2s_frame_ctrl;
    localparam int WIDTH = 16;
    localparam int DIV_W = 8;
    localparam int CNT_W = $clog2(2 * WIDTH);
    localparam int LIM   = 3000;
    localparam int NVEC  = 10;

    logic clk   = 1'b0;
    logic rst_i = 1'b0;

    i2s_frame_ctrl_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    i2s_frame_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic [DIV_W-1:0] div;
        logic [CNT_W+5:0] exp;   // {sclk, ws, rise, fall, done, busy, slot}
    } vec_t;

    vec_t vecs [NVEC];

    int passed = 0;
    int total  = 0;
    int strobe_viol = 0;
    int ws_viol = 0;
    int slot_viol = 0;
    bit mon_en = 1'b0;
    logic p_sclk = 1'b0;
    logic [CNT_W-1:0] p_slot = '0;

    function automatic vec_t mk(input logic en, input int div, input logic sclk, input logic ws,
                                input logic rise, input logic fall, input logic done,
                                input logic busy, input int slot);
        vec_t v;
        v.en  = en;
        v.div = DIV_W'(div);
        v.exp = {sclk, ws, rise, fall, done, busy, CNT_W'(slot)};
        return v;
    endfunction

    function automatic logic [CNT_W+5:0] outs();
        return {bus.sclk_o, bus.ws_o, bus.sclkRise_o, bus.sclkFall_o,
                bus.frameDone_o, bus.busy_o, bus.slotBit_o};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock; sample 1 ns after the edge and track cycle-level invariants
    task automatic tick();
        int ns;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (bus.sclkRise_o && bus.sclkFall_o) strobe_viol++;
            if (bus.sclkRise_o != (bus.sclk_o && !p_sclk)) strobe_viol++;
            if (bus.sclkFall_o != (!bus.sclk_o && p_sclk)) strobe_viol++;
            if (bus.ws_o != (int'(bus.slotBit_o) >= WIDTH - 1 && int'(bus.slotBit_o) <= 2 * WIDTH - 2))
                ws_viol++;
            ns = bus.sclkFall_o ? (int'(p_slot) + 1) % (2 * WIDTH) : int'(p_slot);
            if (int'(bus.slotBit_o) != ns) slot_viol++;
        end
        p_sclk = bus.sclk_o;
        p_slot = bus.slotBit_o;
    endtask

    // sel: 0 frameDone, 1 slotBit==arg, 2 sclkRise, 3 slotBit==arg with sclk high
    task automatic wait_until(input int sel, input int arg, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < LIM) begin
            tick();
            n++;
            case (sel)
                0: found = bus.frameDone_o;
                1: found = (int'(bus.slotBit_o) == arg);
                2: found = bus.sclkRise_o;
                default: found = (int'(bus.slotBit_o) == arg) && bus.sclk_o;
            endcase
        end
        if (!found) begin
            total++;
            $display("FAIL wait_sel%0d: no event within %0d cycles", sel, LIM);
            n = -1;
        end
    endtask

    initial begin
        int n, n1, n2, n3, cnt;

        bus.en_i  = 1'b0;
        bus.div_i = DIV_W'(1);

        // Start-up with div=1; div_i moves to 7 mid-frame and must be ignored
        vecs[0] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[2] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[3] = mk(1, 7, 1, 0, 1, 0, 0, 1, 0);
        vecs[4] = mk(1, 7, 1, 0, 0, 0, 0, 1, 0);
        vecs[5] = mk(1, 7, 0, 0, 0, 1, 0, 1, 1);
        vecs[6] = mk(1, 7, 0, 0, 0, 0, 0, 1, 1);
        vecs[7] = mk(1, 7, 1, 0, 1, 0, 0, 1, 1);
        vecs[8] = mk(1, 7, 1, 0, 0, 0, 0, 1, 1);
        vecs[9] = mk(1, 7, 0, 0, 0, 1, 0, 1, 2);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 0);
        @(negedge clk);
        rst_i = 1'b1;
        mon_en = 1'b1;

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            bus.en_i  = vecs[i].en;
            bus.div_i = vecs[i].div;
            tick();
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        bus.div_i = DIV_W'(1);

        // Steady running at div=1: frame 128 clk, SCLK period 4 clk
        wait_until(0, 0, n);
        wait_until(0, 0, n);
        check("frame_len_div1", n, 128);
        wait_until(2, 0, n);
        wait_until(2, 0, n);
        check("sclk_period_div1", n, 4);

        // Drop en at bitCnt=5: runs to the wrap, then fully idle
        wait_until(1, 5, n);
        bus.en_i = 1'b0;
        wait_until(0, 0, n);
        check("stop_at_wrap", {bus.sclk_o, bus.ws_o, bus.busy_o, bus.slotBit_o}, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.sclkRise_o || bus.sclkFall_o || bus.frameDone_o || bus.busy_o ||
                bus.sclk_o || bus.ws_o) cnt++;
        end
        check("idle_quiet", cnt, 0);

        // div=0: clk/2, strobes alternate every cycle, frame 64 clk
        bus.div_i = '0;
        bus.en_i  = 1'b1;
        wait_until(2, 0, n);
        check("first_rise_div0", n, 2);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("alt%0d", i), {bus.sclkRise_o, bus.sclkFall_o},
                  (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        wait_until(0, 0, n);
        wait_until(0, 0, n);
        check("frame_len_div0", n, 64);

        // Divider change 1->3 mid-frame applies only from the next frame
        bus.div_i = DIV_W'(1);
        wait_until(0, 0, n);
        wait_until(1, 10, n);
        bus.div_i = DIV_W'(3);
        wait_until(2, 0, n);
        wait_until(2, 0, n);
        check("old_div_kept", n, 4);
        wait_until(0, 0, n);
        wait_until(2, 0, n1);
        wait_until(2, 0, n2);
        wait_until(0, 0, n3);
        check("new_div_period", n2, 8);
        check("frame_len_div3", n1 + n2 + n3, 256);

        // en low briefly in STOP, re-asserted before the wrap: no gap
        bus.div_i = DIV_W'(1);
        wait_until(0, 0, n);
        wait_until(1, 3, n1);
        bus.en_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!bus.busy_o) cnt++;
        end
        bus.en_i = 1'b1;
        wait_until(0, 0, n2);
        check("stop_reenter_busy", cnt, 0);
        check("stop_reenter_frame", n1 + 5 + n2, 128);

        // Asynchronous reset at bitCnt=20 with sclk high
        wait_until(3, 20, n);
        #2;
        rst_i  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("reset_async", outs(), 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (outs() != 0) cnt++;
        end
        check("reset_hold", cnt, 0);
        @(negedge clk);
        rst_i = 1'b1;
        tick();
        check("restart", {bus.busy_o, bus.sclk_o, bus.slotBit_o}, {1'b1, 1'b0, CNT_W'(0)});
        mon_en = 1'b1;
        wait_until(0, 0, n);
        check("restart_frame", n, 128);

        check("strobe_rules", strobe_viol, 0);
        check("ws_rule", ws_viol, 0);
        check("slot_sequence", slot_viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
